// File: rtl/timer_dev_pkg.sv
// Shared definitions for the programmable interval timer: register map,
// CTRL bit layout, MODE codes, FSM state encoding and default window base.
package timer_dev_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_7F00;
    localparam int          CTRL_W_DEFAULT    = 4;

    // Word offsets inside the window (PrAddr[3:2])
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_GAP    = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    // MODE codes; 1x behaves like one-shot
    localparam logic [1:0] MODE_ONE_SHOT    = 2'b00;
    localparam logic [1:0] MODE_AUTO_RELOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

    // Only the exact auto-reload code reloads; every other code stops after one period.
    function automatic logic is_auto_reload(input logic [1:0] mode);
        return (mode == MODE_AUTO_RELOAD);
    endfunction

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped interval timer: CTRL/PRESET/COUNT window on the processor
// bus, down-counter FSM, interrupt request and a registered read port.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          CTRL_W    = CTRL_W_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PrAddr,
    input  logic [31:0] PrWD,
    input  logic        PrWe,
    output logic [31:0] PrRD,
    output logic        IRQ
);

    localparam logic [31:0] WINDOW_MASK = 32'hFFFF_FFF0;

    timer_state_e      state_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [31:0]       preset_r;
    logic [31:0]       count_r;
    logic              irq_flag_r;

    logic              hit_s;
    logic [1:0]        addr_idx_s;
    logic              wr_ctrl_s;
    logic              wr_preset_s;
    logic              auto_reload_s;
    logic [31:0]       rd_data_s;

    // Byte-lane bits of PrAddr fall away in the mask, so any byte address hits its word.
    assign addr_idx_s    = PrAddr[3:2];
    assign hit_s         = ((PrAddr & WINDOW_MASK) == (BASE_ADDR & WINDOW_MASK)) &&
                           (addr_idx_s != OFF_GAP);
    assign wr_ctrl_s     = PrWe && hit_s && (addr_idx_s == OFF_CTRL);
    assign wr_preset_s   = PrWe && hit_s && (addr_idx_s == OFF_PRESET);
    assign auto_reload_s = is_auto_reload(ctrl_r[CTRL_MODE_MSB:CTRL_MODE_LSB]);

    // Flag and mask are both registers, so IRQ falls the instant reset clears them.
    assign IRQ = irq_flag_r & ctrl_r[CTRL_IM_BIT];

    // Read mux over the current register contents (before any same-cycle write).
    always_comb begin
        rd_data_s = 32'd0;
        if (hit_s) begin
            case (addr_idx_s)
                OFF_CTRL:   rd_data_s = {{(32-CTRL_W){1'b0}}, ctrl_r};
                OFF_PRESET: rd_data_s = preset_r;
                OFF_COUNT:  rd_data_s = count_r;
                default:    rd_data_s = 32'd0;
            endcase
        end else begin
            rd_data_s = 32'd0;
        end
    end

    // Registered read data so the CPU samples it one stage later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PrRD <= 32'd0;
        end else begin
            PrRD <= rd_data_s;
        end
    end

    // PRESET is only ever changed by the bus; COUNT picks it up at the next LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset_r <= 32'd0;
        end else if (wr_preset_s) begin
            preset_r <= PrWD;
        end
    end

    // Counter FSM with CTRL and irq_flag; bus writes are applied last so they win.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            ctrl_r     <= {CTRL_W{1'b0}};
            count_r    <= 32'd0;
            irq_flag_r <= 1'b0;
        end else begin
            if (wr_ctrl_s && !PrWD[CTRL_EN_BIT]) begin
                // Disabling from the bus parks the FSM and freezes COUNT.
                state_r <= ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (ctrl_r[CTRL_EN_BIT]) begin
                            state_r <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        count_r <= preset_r;
                        state_r <= ST_CNT;
                    end
                    ST_CNT: begin
                        if (!ctrl_r[CTRL_EN_BIT]) begin
                            state_r <= ST_IDLE;
                        end else if (count_r > 32'd1) begin
                            count_r <= count_r - 32'd1;
                        end else begin
                            // Terminal count: saturate at zero and raise the flag on entry to INT.
                            count_r    <= 32'd0;
                            irq_flag_r <= 1'b1;
                            state_r    <= ST_INT;
                        end
                    end
                    ST_INT: begin
                        if (auto_reload_s) begin
                            irq_flag_r <= 1'b0;
                            state_r    <= ST_LOAD;
                        end else begin
                            ctrl_r[CTRL_EN_BIT] <= 1'b0;
                            state_r             <= ST_IDLE;
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end

            if (wr_ctrl_s) begin
                ctrl_r <= PrWD[CTRL_W-1:0];
            end
            if (wr_ctrl_s || wr_preset_s) begin
                irq_flag_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev: directed bus operations push expected PrRD/IRQ into a
// scoreboard; a monitor pops and compares one cycle after each checked access.
module tb_timer_dev;

    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
    localparam logic [31:0] A_GAP    = 32'h0000_7F0C;
    localparam logic [31:0] A_MISS   = 32'h0000_7E04;
    localparam logic [31:0] A_IDLE   = 32'h0000_1000;

    logic        clk;
    logic        reset;
    logic [31:0] PrAddr;
    logic [31:0] PrWD;
    logic        PrWe;
    logic [31:0] PrRD;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    logic        rd_flag = 1'b0;
    logic        rd_pend = 1'b0;
    logic [31:0] exp_rd_q [$];
    logic        exp_irq_q [$];
    string       name_q [$];

    logic [31:0] t3_cnt [13];
    logic        t3_irq [13];

    timer_dev dut (
        .clk    (clk),
        .reset  (reset),
        .PrAddr (PrAddr),
        .PrWD   (PrWD),
        .PrWe   (PrWe),
        .PrRD   (PrRD),
        .IRQ    (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A checked access captured on this edge is presented on the next negedge.
    always @(posedge clk) rd_pend <= rd_flag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle; when chk is set the expected PrRD/IRQ after the edge is queued.
    task automatic bus_op(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                          input logic chk, input logic [31:0] exp_rd, input logic exp_irq,
                          input string name);
        PrAddr = addr;
        PrWe   = we;
        PrWD   = wd;
        if (chk) begin
            exp_rd_q.push_back(exp_rd);
            exp_irq_q.push_back(exp_irq);
            name_q.push_back(name);
            rd_flag = 1'b1;
        end
        @(posedge clk);
        #2;
        PrWe    = 1'b0;
        PrAddr  = A_IDLE;
        rd_flag = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        bus_op(addr, 1'b1, wd, 1'b0, 32'd0, 1'b0, "");
    endtask

    task automatic wrc(input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_irq, input string name);
        bus_op(addr, 1'b1, wd, 1'b1, exp_rd, exp_irq, name);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_rd,
                      input logic exp_irq, input string name);
        bus_op(addr, 1'b0, 32'd0, 1'b1, exp_rd, exp_irq, name);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            bus_op(A_IDLE, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, "");
        end
    endtask

    // Asynchronous reset away from any edge; outputs must clear without a clock.
    task automatic pulse_reset(input string name);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check({name, ".irq"}, {31'd0, IRQ}, 32'd0);
        check({name, ".prrd"}, PrRD, 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever a checked response is due.
    initial begin : monitor
        string       nm;
        logic [31:0] er;
        logic        ei;
        forever begin
            @(negedge clk);
            if (rd_pend) begin
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got 1 response expected 0 queued");
                end else begin
                    er = exp_rd_q.pop_front();
                    ei = exp_irq_q.pop_front();
                    nm = name_q.pop_front();
                    check({nm, ".rd"}, PrRD, er);
                    check({nm, ".irq"}, {31'd0, IRQ}, {31'd0, ei});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        t3_cnt = '{32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd2,
                   32'd1, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0};
        t3_irq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        reset  = 1'b0;
        PrAddr = A_IDLE;
        PrWD   = 32'd0;
        PrWe   = 1'b0;
        #1;
        check("rst.irq", {31'd0, IRQ}, 32'd0);
        check("rst.prrd", PrRD, 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;

        // One-shot, PRESET=3: IRQ on the 5th edge after the CTRL write, held until cleared.
        wr(A_PRESET, 32'd3);
        wr(A_CTRL, 32'h9);
        rd(A_COUNT, 32'd0, 1'b0, "t2_e1");
        rd(A_COUNT, 32'd0, 1'b0, "t2_e2");
        rd(A_COUNT, 32'd3, 1'b0, "t2_e3");
        rd(A_COUNT, 32'd2, 1'b0, "t2_e4");
        rd(A_COUNT, 32'd1, 1'b1, "t2_e5");
        rd(A_CTRL, 32'h9, 1'b1, "t2_ctrl_a");
        rd(A_CTRL, 32'h8, 1'b1, "t2_en_off");
        rd(A_COUNT, 32'd0, 1'b1, "t2_cnt0");
        idle(3);
        rd(A_CTRL, 32'h8, 1'b1, "t2_hold");
        wrc(A_CTRL, 32'h0, 32'h8, 1'b0, "t2_clr");
        rd(A_CTRL, 32'h0, 1'b0, "t2_ctrl0");

        // Auto-reload, PRESET=2: one-cycle pulse every 4 cycles.
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'hB);
        for (int i = 0; i < 13; i++) begin
            rd(A_COUNT, t3_cnt[i], t3_irq[i], $sformatf("t3_e%0d", i + 1));
        end
        wrc(A_CTRL, 32'h0, 32'hB, 1'b0, "t3_stop");
        rd(A_COUNT, 32'd0, 1'b0, "t3_held");
        idle(2);
        rd(A_COUNT, 32'd0, 1'b0, "t3_idle");

        // IM=0 masks IRQ; setting IM with EN clears the stale flag.
        wr(A_PRESET, 32'd1);
        wr(A_CTRL, 32'h1);
        rd(A_CTRL, 32'h1, 1'b0, "t4_e1");
        rd(A_CTRL, 32'h1, 1'b0, "t4_e2");
        rd(A_CTRL, 32'h1, 1'b0, "t4_e3");
        rd(A_CTRL, 32'h1, 1'b0, "t4_e4");
        rd(A_CTRL, 32'h0, 1'b0, "t4_e5");
        wrc(A_CTRL, 32'h9, 32'h0, 1'b0, "t4_im_on");
        rd(A_CTRL, 32'h9, 1'b0, "t4_r1");
        rd(A_CTRL, 32'h9, 1'b0, "t4_r2");
        rd(A_CTRL, 32'h9, 1'b1, "t4_r3");
        wrc(A_CTRL, 32'h0, 32'h9, 1'b0, "t4_clr");

        // Decode, read latency, ignored writes.
        wrc(A_PRESET, 32'hDEAD_BEEF, 32'd1, 1'b0, "t5_wpre");
        rd(A_PRESET, 32'hDEAD_BEEF, 1'b0, "t5_rpre");
        rd(32'h0000_7F07, 32'hDEAD_BEEF, 1'b0, "t5_bytelane");
        rd(A_GAP, 32'd0, 1'b0, "t5_gap");
        wrc(A_COUNT, 32'h0001_2345, 32'd0, 1'b0, "t5_wcnt");
        rd(A_COUNT, 32'd0, 1'b0, "t5_rcnt");
        wrc(A_MISS, 32'h55, 32'd0, 1'b0, "t5_miss");
        rd(A_PRESET, 32'hDEAD_BEEF, 1'b0, "t5_pre_kept");
        wrc(A_PRESET, 32'h1111, 32'hDEAD_BEEF, 1'b0, "t5_rbw");
        rd(A_PRESET, 32'h1111, 1'b0, "t5_new");

        // PRESET=0: INT on the 3rd edge; CTRL write in INT beats the FSM's EN clear.
        wrc(A_PRESET, 32'd0, 32'h1111, 1'b0, "t6_wpre");
        wr(A_CTRL, 32'h9);
        rd(A_CTRL, 32'h9, 1'b0, "t6_e1");
        rd(A_CTRL, 32'h9, 1'b0, "t6_e2");
        rd(A_CTRL, 32'h9, 1'b1, "t6_e3");
        wrc(A_CTRL, 32'h9, 32'h9, 1'b0, "t6_wint");
        rd(A_CTRL, 32'h9, 1'b0, "t6_kept");
        rd(A_CTRL, 32'h9, 1'b0, "t6_e6");
        rd(A_CTRL, 32'h9, 1'b1, "t6_e7");
        rd(A_CTRL, 32'h9, 1'b1, "t6_e8");
        rd(A_CTRL, 32'h8, 1'b1, "t6_e9");
        pulse_reset("t6_rst");
        rd(A_CTRL, 32'h0, 1'b0, "t6_ctrl");
        rd(A_COUNT, 32'd0, 1'b0, "t6_count");

        // Reset mid-count at COUNT=5.
        wr(A_PRESET, 32'd10);
        wr(A_CTRL, 32'h9);
        idle(6);
        rd(A_COUNT, 32'd6, 1'b0, "t1_cnt6");
        pulse_reset("t1_rst");
        rd(A_CTRL, 32'h0, 1'b0, "t1_ctrl");
        rd(A_PRESET, 32'h0, 1'b0, "t1_preset");
        rd(A_COUNT, 32'h0, 1'b0, "t1_count");
        idle(3);
        rd(A_COUNT, 32'h0, 1'b0, "t1_still");

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", exp_rd_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
